// File: rtl/ntt_pkg.sv
// ntt_pkg: constants and types shared by the NTT post-processing blocks.
//   DATA_WIDTH / Q / N_INV : coefficient width, modulus, N^-1 mod Q for N=256
//   BARRETT_K / BARRETT_M  : Barrett shift and multiplier floor(2^K / Q)
//   intt_state_e           : sequencer states for intt_scale_unit
package ntt_pkg;

  localparam int unsigned DATA_WIDTH = 12;
  localparam int unsigned Q          = 3329;
  localparam int unsigned N_INV      = 3316;
  localparam int unsigned BARRETT_K  = 24;
  localparam int unsigned BARRETT_M  = (2 ** BARRETT_K) / Q;  // 5039

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } intt_state_e;

endpackage

// File: rtl/mod_mul_const.sv
// mod_mul_const: two-stage pipelined multiply by a constant followed by
// Barrett reduction, producing (in_data * CONST) mod Q in [0, Q-1].
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_data/in_index   : operand beat
//   out_valid/out_data/out_index: reduced result, two cycles later
// Valid for any in_data in [0, 2^DATA_WIDTH-1] as long as the product fits
// below 2^BARRETT_K, so one conditional subtraction always suffices.
module mod_mul_const #(
  parameter int unsigned DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int unsigned IDX_WIDTH  = 8,
  parameter int unsigned Q          = ntt_pkg::Q,
  parameter int unsigned CONST      = ntt_pkg::N_INV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [IDX_WIDTH-1:0]  in_index,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_index
);
  import ntt_pkg::*;

  localparam int unsigned PW = 2 * DATA_WIDTH;        // product width
  localparam int unsigned EW = PW + BARRETT_K;        // Barrett estimate width
  localparam int unsigned RW = DATA_WIDTH + 1;        // remainder < 2Q
  localparam int unsigned BM = (2 ** BARRETT_K) / Q;

  localparam logic [PW-1:0] CONST_W = PW'(CONST);
  localparam logic [PW-1:0] Q_P     = PW'(Q);
  localparam logic [EW-1:0] M_W     = EW'(BM);
  localparam logic [RW-1:0] Q_R     = RW'(Q);

  logic                 a_valid;
  logic [IDX_WIDTH-1:0] a_idx;
  logic [PW-1:0]        a_prod;

  logic [PW-1:0]         quot;
  logic [RW-1:0]         rem;
  logic [DATA_WIDTH-1:0] reduced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_idx   <= '0;
      a_prod  <= '0;
    end else begin
      a_valid <= in_valid;
      a_idx   <= in_index;
      a_prod  <= PW'(in_data) * CONST_W;
    end
  end

  // Quotient estimate undershoots by at most one, so the true remainder is
  // below 2Q and the low RW bits of the difference are exact.
  always_comb begin
    quot    = PW'((EW'(a_prod) * M_W) >> BARRETT_K);
    rem     = RW'(a_prod - quot * Q_P);
    reduced = DATA_WIDTH'((rem >= Q_R) ? (rem - Q_R) : rem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= a_valid;
      out_index <= a_idx;
      out_data  <= reduced;
    end
  end

endmodule

// File: rtl/intt_scale_unit.sv
// intt_scale_unit: final inverse-NTT pass; sweeps the coefficient RAM once,
// multiplying every coefficient by N^-1 mod Q and writing it back in place,
// one coefficient per cycle.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : level request, honoured only in IDLE
//   busy / done      : RUN or DRAIN / DONE
//   ram_raddr/ram_re : read port; ram_rdata arrives one cycle after ram_re
//   ram_waddr/ram_wdata/ram_we : write port, trails reads by three cycles
//   m_valid/m_index/m_data     : optional copy of the write stream, present
//                                only when INTT_SCALE_STREAM_EN is defined
module intt_scale_unit #(
  parameter int unsigned N          = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = ntt_pkg::DATA_WIDTH,
  parameter int unsigned Q          = ntt_pkg::Q,
  parameter int unsigned N_INV      = ntt_pkg::N_INV
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we
`ifdef INTT_SCALE_STREAM_EN
  ,
  output logic                  m_valid,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic [DATA_WIDTH-1:0] m_data
`endif
);
  import ntt_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

  intt_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [1:0]            drain_cnt;
  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start)                 state_d = ST_RUN;
      ST_RUN:   if (rd_idx == LAST_IDX)    state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 2'd2)     state_d = ST_DONE;
      ST_DONE:  if (!start)                state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with
  // state_q and never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx    <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_idx    <= (state_q == ST_RUN && rd_idx != LAST_IDX) ? rd_idx + 1'b1 : '0;
      drain_cnt <= (state_q == ST_DRAIN) ? drain_cnt + 2'd1 : '0;
      busy      <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done      <= (state_d == ST_DONE);
    end
  end

  assign ram_re    = (state_q == ST_RUN);
  assign ram_raddr = rd_idx;

  // S1: the RAM's own output register holds the data; this stage carries the
  // matching valid/index so they arrive alongside ram_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= ram_re;
      s1_idx   <= rd_idx;
    end
  end

  mod_mul_const #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (ADDR_WIDTH),
    .Q          (Q),
    .CONST      (N_INV)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_data   (ram_rdata),
    .in_index  (s1_idx),
    .out_valid (ram_we),
    .out_data  (ram_wdata),
    .out_index (ram_waddr)
  );

`ifdef INTT_SCALE_STREAM_EN
  assign m_valid = ram_we;
  assign m_index = ram_waddr;
  assign m_data  = ram_wdata;
`endif

endmodule

// File: tb/tb_intt_scale_unit.sv
// tb_intt_scale_unit: drives intt_scale_unit against a behavioural
// synchronous RAM; a scoreboard queues the expected write for every read and
// checks it when the write appears. Define INTT_SCALE_STREAM_EN to also check
// the mirrored result stream.
module tb_intt_scale_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic          ram_re, ram_we;
  logic [DW-1:0] ram_rdata, ram_wdata;
`ifdef INTT_SCALE_STREAM_EN
  logic          m_valid;
  logic [AW-1:0] m_index;
  logic [DW-1:0] m_data;
`endif

  intt_scale_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_raddr (ram_raddr),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
`ifdef INTT_SCALE_STREAM_EN
    ,
    .m_valid   (m_valid),
    .m_index   (m_index),
    .m_data    (m_data)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] pre [256];

  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem[ram_raddr];
    if (ram_we) mem[ram_waddr] <= ram_wdata;
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_f(input int unsigned x);
    return DW'((x * 3316) % 3329);
  endfunction

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t sb[$];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          seen_re, seen_we, seen_done;
  int unsigned first_re_cyc, first_we_cyc, done_cyc;
  int unsigned busy_cnt, re_cnt, we_cnt;

  always @(negedge clk) begin
    if (busy && done) check("busy_done_overlap", 1, 0);
    if (ram_we && !busy) check("we_outside_busy", 1, 0);
`ifdef INTT_SCALE_STREAM_EN
    check("m_valid", m_valid, ram_we);
    if (m_valid) begin
      check("m_index", m_index, ram_waddr);
      check("m_data", m_data, ram_wdata);
    end
`endif
    if (busy) busy_cnt++;
    if (done && !seen_done) begin
      seen_done = 1'b1;
      done_cyc  = cyc;
    end
    if (ram_re) begin
      exp_t e;
      e.idx  = ram_raddr;
      e.data = exp_f(pre[ram_raddr]);
      e.cyc  = cyc;
      sb.push_back(e);
      re_cnt++;
      if (!seen_re) begin
        seen_re      = 1'b1;
        first_re_cyc = cyc;
      end
    end
    if (ram_we) begin
      we_cnt++;
      if (!seen_we) begin
        seen_we      = 1'b1;
        first_we_cyc = cyc;
      end
      if (sb.size() == 0) begin
        check("we_without_read", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("waddr", ram_waddr, e.idx);
        check("wdata", ram_wdata, e.data);
        check("rd_wr_latency", cyc - e.cyc, 3);
      end
    end
  end

  task automatic clear_mon();
    sb.delete();
    seen_re   = 1'b0;
    seen_we   = 1'b0;
    seen_done = 1'b0;
    busy_cnt  = 0;
    re_cnt    = 0;
    we_cnt    = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_re", ram_re, 0);
    check("rst_we", ram_we, 0);
    check("rst_raddr", ram_raddr, 0);
    check("rst_waddr", ram_waddr, 0);
    check("rst_wdata", ram_wdata, 0);
`ifdef INTT_SCALE_STREAM_EN
    check("rst_m_valid", m_valid, 0);
    check("rst_m_index", m_index, 0);
    check("rst_m_data", m_data, 0);
`endif
  endtask

  // One full pass; start is pulsed unless hold_start is set, in which case
  // it stays high through DONE to confirm there is no second pass.
  task automatic run_pass(input string name, input bit hold_start);
    int unsigned t0;
    int unsigned re_snap;
    @(negedge clk);
    clear_mon();
    t0    = cyc;
    start = 1'b1;
    if (!hold_start) begin
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 600 && !seen_done; i++) @(negedge clk);
    check({name, "_done_seen"}, seen_done, 1);
    check({name, "_first_re"}, first_re_cyc - t0, 1);
    check({name, "_first_we"}, first_we_cyc - t0, 4);
    check({name, "_done_cycle"}, done_cyc - t0, 260);
    check({name, "_busy_cycles"}, busy_cnt, 259);
    check({name, "_reads"}, re_cnt, 256);
    check({name, "_writes"}, we_cnt, 256);
    check({name, "_sb_empty"}, sb.size(), 0);
    for (int unsigned i = 0; i < 256; i++)
      check({name, "_mem"}, mem[i], exp_f(pre[i]));
    if (hold_start) begin
      re_snap = re_cnt;
      repeat (20) @(negedge clk);
      check({name, "_hold_done"}, done, 1);
      check({name, "_hold_busy"}, busy, 0);
      check({name, "_hold_no_reads"}, re_cnt, re_snap);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check({name, "_idle_done"}, done, 0);
      check({name, "_idle_busy"}, busy, 0);
    end else begin
      repeat (2) @(negedge clk);
      check({name, "_pulse_done_low"}, done, 0);
    end
  endtask

  task automatic load_mem(input int unsigned kind);
    for (int unsigned i = 0; i < 256; i++) begin
      case (kind)
        0:       pre[i] = 12'd1;
        1:       pre[i] = DW'(i % 3329);
        default: pre[i] = DW'($urandom_range(0, 4095));
      endcase
    end
    if (kind == 2) begin
      pre[10] = 12'd3328;
      pre[11] = 12'd4095;
      pre[12] = 12'd3329;
      pre[13] = 12'd0;
      pre[255] = 12'd4095;
    end
    for (int unsigned i = 0; i < 256; i++) mem[i] = pre[i];
  endtask

  initial begin
    int unsigned t0;
    rst_n = 1'b0;
    start = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    load_mem(0);
    run_pass("ones", 1'b1);
    check("ones_addr0", mem[0], 3316);
    check("ones_addr255", mem[255], 3316);

    load_mem(1);
    run_pass("ramp", 1'b0);
    check("ramp_addr0", mem[0], 0);
    check("ramp_addr2", mem[2], 3303);

    load_mem(2);
    run_pass("edge", 1'b0);
    check("x3328", mem[10], 13);
    check("x4095", mem[11], 29);
    check("x3329", mem[12], 0);
    check("x0", mem[13], 0);
    check("x4095_last", mem[255], 29);

    // Reset in the middle of a pass.
    load_mem(3);
    @(negedge clk);
    clear_mon();
    t0    = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && (cyc - t0) < 100; i++) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_idle_busy", busy, 0);

    load_mem(3);
    run_pass("after_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
